// File: rtl/alu_mc_pkg.sv
// alu_mc_pkg -- shared type definitions for the alu_mc block.
//   op_e     : 3-bit opcode carried on selop
//   shmode_e : 2-bit post-shift mode carried on shmode
//   state_e  : sequencing FSM states (IDLE, MUL, DONE)
package alu_mc_pkg;

    typedef enum logic [2:0] {
        OP_ADD   = 3'b000,
        OP_SUB   = 3'b001,
        OP_AND   = 3'b010,
        OP_OR    = 3'b011,
        OP_XOR   = 3'b100,
        OP_NOTA  = 3'b101,
        OP_PASSB = 3'b110,
        OP_MUL   = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        SH_NONE = 2'b00,
        SH_SLL  = 2'b01,
        SH_SRL  = 2'b10,
        SH_SRA  = 2'b11
    } shmode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MUL  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

endpackage

// File: rtl/alu_mc_mul.sv
// alu_mc_mul -- iterative shift-add unsigned multiplier, WIDTH x WIDTH.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   load     : capture a/b and perform the first iteration on this edge
//   a, b     : multiplicand / multiplier
//   busy     : high while further iterations remain
//   prod     : 2*WIDTH-bit product, final once busy falls
// The first iteration is folded into the load edge so the full product is
// already present in the cycle in which busy reads low; the parent FSM can
// therefore leave its MUL state on !busy and register prod on that edge.
module alu_mc_mul #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic [2*WIDTH-1:0]   prod
);

    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0] mcand_r;
    logic [CW-1:0]    count_r;
    logic [WIDTH:0]   step_s;
    logic [WIDTH:0]   first_s;

    // Partial-sum adders: running upper half plus the gated multiplicand
    always_comb begin
        step_s  = {1'b0, prod[2*WIDTH-1:WIDTH]};
        first_s = {(WIDTH+1){1'b0}};
        if (prod[0]) begin
            step_s = {1'b0, prod[2*WIDTH-1:WIDTH]} + {1'b0, mcand_r};
        end else begin
            step_s = {1'b0, prod[2*WIDTH-1:WIDTH]};
        end
        if (b[0]) begin
            first_s = {1'b0, a};
        end else begin
            first_s = {(WIDTH+1){1'b0}};
        end
    end

    // Product/iteration register; each step adds then shifts right by one
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand_r <= '0;
            prod    <= '0;
            count_r <= '0;
            busy    <= 1'b0;
        end else if (load) begin
            mcand_r <= a;
            prod    <= {first_s, b[WIDTH-1:1]};
            count_r <= CW'(WIDTH - 1);
            busy    <= 1'b1;
        end else if (busy) begin
            prod    <= {step_s, prod[WIDTH-1:1]};
            count_r <= count_r - CW'(1);
            if (count_r == CW'(1)) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_mc.sv
// alu_mc -- multi-cycle ALU with post-shifter and registered flags.
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   start             : operation request, accepted only in IDLE
//   busA, busB        : operands
//   selop             : opcode (see alu_mc_pkg::op_e)
//   shmode, shamt     : post-shift mode/amount (single-cycle ops only)
//   enaf              : flag-update enable for this operation
//   busy              : high while a MUL iterates
//   done              : one-cycle pulse when busC/busH are valid
//   busC, busH        : result low half, MUL high half (held until next done)
//   C, N, P, Z        : carry, negative, odd parity, zero flags
// Configuration macro ALU_MC_MUL_EN: when defined, selop=111 runs the
// iterative multiplier (WIDTH+1 cycle latency). When undefined, selop=111 is
// a single-cycle op returning zero and leaving the flags untouched.
module alu_mc
    import alu_mc_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] busA,
    input  logic [WIDTH-1:0] busB,
    input  logic [2:0]       selop,
    input  logic [1:0]       shmode,
    input  logic [SHW-1:0]   shamt,
    input  logic             enaf,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] busC,
    output logic [WIDTH-1:0] busH,
    output logic             C,
    output logic             N,
    output logic             P,
    output logic             Z
);

    function automatic logic odd_parity(input logic [WIDTH-1:0] v);
        return ^v;
    endfunction

    state_e           state_r;
    state_e           state_next_s;
    op_e              op_s;
    shmode_e          sh_s;
    logic [WIDTH:0]   sum_s;
    logic [WIDTH-1:0] alu_s;
    logic [WIDTH-1:0] shifted_s;
    logic             alu_c_s;
    logic             accept_s;
    logic             is_mul_s;
    logic             mul_path_s;

    assign op_s     = op_e'(selop);
    assign sh_s     = shmode_e'(shmode);
    assign accept_s = (state_r == ST_IDLE) && start;
    assign is_mul_s = (op_s == OP_MUL);

`ifdef ALU_MC_MUL_EN
    logic                 enaf_r;
    logic                 mul_busy_s;
    logic                 mul_done_s;
    logic [2*WIDTH-1:0]   mul_prod_s;

    // Only a MUL takes the iterative path; everything else completes at once
    assign mul_path_s = is_mul_s;
    assign mul_done_s = (state_r == ST_MUL) && !mul_busy_s;

    alu_mc_mul #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk  (clk),
        .rst  (rst),
        .load (accept_s && is_mul_s),
        .a    (busA),
        .b    (busB),
        .busy (mul_busy_s),
        .prod (mul_prod_s)
    );

    // Flag-enable is the only MUL control needed after the start edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            enaf_r <= 1'b0;
        end else if (accept_s) begin
            enaf_r <= enaf;
        end
    end
`else
    assign mul_path_s = 1'b0;
`endif

    // Opcode decode: raw result and carry ahead of the post-shifter
    always_comb begin
        sum_s   = '0;
        alu_s   = '0;
        alu_c_s = 1'b0;
        case (op_s)
            OP_ADD: begin
                sum_s   = {1'b0, busA} + {1'b0, busB};
                alu_s   = sum_s[WIDTH-1:0];
                alu_c_s = sum_s[WIDTH];
            end
            OP_SUB: begin
                // Carry out of A + ~B + 1 is 1 when no borrow occurred
                sum_s   = {1'b0, busA} + {1'b0, ~busB} + {{WIDTH{1'b0}}, 1'b1};
                alu_s   = sum_s[WIDTH-1:0];
                alu_c_s = sum_s[WIDTH];
            end
            OP_AND:   alu_s = busA & busB;
            OP_OR:    alu_s = busA | busB;
            OP_XOR:   alu_s = busA ^ busB;
            OP_NOTA:  alu_s = ~busA;
            OP_PASSB: alu_s = busB;
            OP_MUL:   alu_s = '0;
            default:  alu_s = '0;
        endcase
    end

    // Post-shifter; flags are taken from alu_s, not from the shifted value
    always_comb begin
        shifted_s = alu_s;
        case (sh_s)
            SH_NONE: shifted_s = alu_s;
            SH_SLL:  shifted_s = alu_s << shamt;
            SH_SRL:  shifted_s = alu_s >> shamt;
            SH_SRA:  shifted_s = WIDTH'($signed(alu_s) >>> shamt);
            default: shifted_s = alu_s;
        endcase
    end

    // FSM next-state: start only matters in IDLE
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start && mul_path_s) begin
                    state_next_s = ST_MUL;
                end else if (start) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_MUL: begin
`ifdef ALU_MC_MUL_EN
                if (mul_done_s) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_MUL;
                end
`else
                state_next_s = ST_IDLE;
`endif
            end
            ST_DONE: state_next_s = ST_IDLE;
            default: state_next_s = ST_IDLE;
        endcase
    end

    // FSM state register with busy/done registered from the next state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_r <= state_next_s;
            busy    <= (state_next_s == ST_MUL);
            done    <= (state_next_s == ST_DONE);
        end
    end

    // Result and flag registers, loaded on the edge that enters DONE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busC <= '0;
            busH <= '0;
            C    <= 1'b0;
            N    <= 1'b0;
            P    <= 1'b0;
            Z    <= 1'b0;
        end else if (accept_s && !mul_path_s) begin
            busC <= shifted_s;
            busH <= '0;
            // Without the multiplier a MUL opcode never touches the flags
            if (enaf && !is_mul_s) begin
                C <= alu_c_s;
                N <= alu_s[WIDTH-1];
                P <= odd_parity(alu_s);
                Z <= (alu_s == '0);
            end
        end
`ifdef ALU_MC_MUL_EN
        else if (mul_done_s) begin
            busC <= mul_prod_s[WIDTH-1:0];
            busH <= mul_prod_s[2*WIDTH-1:WIDTH];
            if (enaf_r) begin
                C <= |mul_prod_s[2*WIDTH-1:WIDTH];
                N <= mul_prod_s[WIDTH-1];
                P <= odd_parity(mul_prod_s[WIDTH-1:0]);
                Z <= (mul_prod_s[WIDTH-1:0] == '0);
            end
        end
`endif
    end

endmodule
